branch_ctrl: RTL and testbench
==============================

# branch_ctrl

Multicycle branch/jump resolution unit. It accepts one control-transfer request from the main controller together with the CMP flag outputs (zero, great, less, lez, ltz). It evaluates the condition, computes the next PC and link value, and returns a registered result through a valid/ack handshake. It sits between the compare unit and the PC register write path.

## Interface
- No parameters; all widths fixed (32-bit datapath).
- clk  in  1  rising-edge clock
- rstn  in  1  synchronous, active-low reset
- start  in  1  request strobe; accepted only while ready=1
- ready  out  1  high in IDLE
- br_op  in  4  operation code (see Operation)
- zero, great, less, lez, ltz  in  1 each  CMP flags for the current operands
- pc4  in  32  address of the branch instruction + 4
- imm16  in  16  branch offset, in words
- instr_index  in  26  J-type target field
- rs_val  in  32  register value for JR/JALR
- res_valid  out  1  result valid; held until acknowledged
- res_ack  in  1  consumer acknowledge
- taken  out  1  transfer taken
- npc  out  32  next PC
- link_we  out  1  write link register
- link_val  out  32  link value
- bad_op  out  1  br_op was illegal
- br_count  out  32  resolved-request counter (stats build only)
- br_taken_count  out  32  taken counter (stats build only)

## Operation
- br_op encoding and condition:
  - 0 NOP: never taken
  - 1 BEQ: zero
  - 2 BNE: !zero
  - 3 BLEZ: lez
  - 4 BGTZ: !lez
  - 5 BLTZ: ltz
  - 6 BGEZ: !ltz
  - 7 J, 8 JAL, 9 JR, 10 JALR: always taken
  - 11 BGT: great
  - 12 BLT: less
  - 13-15: illegal, not taken, bad_op=1
- FSM states:
  - IDLE: ready=1. On start=1, latch br_op, the five flags, pc4, imm16, instr_index and rs_val, then go to EVAL.
  - EVAL: compute the result and register all result outputs, then go to HOLD.
  - HOLD: res_valid=1 and all result outputs stable. On res_ack=1 go to IDLE.
- Target arithmetic:
  - Branches 1-6, 11, 12: npc = pc4 + ({{14{imm16[15]}}, imm16, 2'b00}), modulo 2^32. Wrap-around is silent.
  - J/JAL: npc = {pc4[31:28], instr_index, 2'b00}.
  - JR/JALR: npc = rs_val unmodified, including the low 2 bits.
  - Not taken or illegal: npc = pc4.
- Link: link_we=1 only for JAL and JALR. link_val = pc4 (no delay slot). Otherwise link_val = 0.
- Inputs are sampled only on the accepting edge. Later changes to the flags or operands do not affect the in-flight result.
- start while not in IDLE is ignored. No queueing.
- res_ack outside HOLD is ignored.

## Timing
- Reset: when rstn=0 at a rising edge, the FSM goes to IDLE from any state, abandoning any transaction. After that edge:
  - ready=1
  - res_valid=0, taken=0, npc=0, link_we=0, link_val=0, bad_op=0
  - counters=0
- Latency: start accepted at edge E0 → res_valid=1 after edge E1 (E0+1 cycle).
- The result stays valid through any number of stall cycles until res_ack.
- ack sampled at edge Ek → res_valid=0 and ready=1 after Ek.
- A new start may be presented the cycle after ack. Throughput is one request per 3 cycles minimum.
- Result outputs keep their last value in IDLE and EVAL. Only res_valid qualifies them.

## Configuration
- BRANCH_STATS_EN defined: at each EVAL→HOLD transition, br_count increments by 1. br_taken_count also increments by 1 when taken. Both counters saturate at 32'hFFFF_FFFF and clear on reset.
- BRANCH_STATS_EN undefined: both ports remain and are tied to 32'h0. No counter logic.

## Test plan
- Reset mid-HOLD: issue BEQ, then rstn=0 while res_valid=1 → next cycle res_valid=0, ready=1, npc=0, taken=0.
- BEQ, zero=1, pc4=0x0040_0010, imm16=0xFFFC → res_valid one cycle after accept, taken=1, npc=0x0040_0000, link_we=0. Hold ack low for 5 cycles → outputs unchanged.
- BGEZ, ltz=1, pc4=0x1000 → taken=0, npc=0x1000.
- JAL, pc4=0xA000_0004, instr_index=0x0000100 → npc=0xA000_0400, link_we=1, link_val=0xA000_0004.
- JALR, rs_val=0x0000_3003 → npc=0x0000_3003. br_op=14 → bad_op=1, taken=0. start asserted during HOLD → ignored, no second result.
- BRANCH_STATS_EN: 3 requests, 2 taken → br_count=3, br_taken_count=2. Without the macro → both 0.

Source files
------------

// File: rtl/branch_ctrl_if.sv
// branch_ctrl_if: request/result bundle between the main controller
// (master) and the branch resolution unit (slave).
interface branch_ctrl_if;
    // request side
    logic        start;
    logic        ready;
    logic [3:0]  br_op;
    logic        zero;
    logic        great;
    logic        less;
    logic        lez;
    logic        ltz;
    logic [31:0] pc4;
    logic [15:0] imm16;
    logic [25:0] instr_index;
    logic [31:0] rs_val;

    // result side
    logic        res_valid;
    logic        res_ack;
    logic        taken;
    logic [31:0] npc;
    logic        link_we;
    logic [31:0] link_val;
    logic        bad_op;

    // statistics
    logic [31:0] br_count;
    logic [31:0] br_taken_count;

    modport master (
        output start, br_op, zero, great, less, lez, ltz,
               pc4, imm16, instr_index, rs_val, res_ack,
        input  ready, res_valid, taken, npc, link_we, link_val, bad_op,
               br_count, br_taken_count
    );

    modport slave (
        input  start, br_op, zero, great, less, lez, ltz,
               pc4, imm16, instr_index, rs_val, res_ack,
        output ready, res_valid, taken, npc, link_we, link_val, bad_op,
               br_count, br_taken_count
    );
endinterface

// File: rtl/branch_ctrl.sv
// branch_ctrl: multicycle branch/jump resolution unit.
// IDLE latches one request, EVAL resolves condition/target/link into the
// result registers, HOLD presents them until acknowledged.
// Optional feature macro: BRANCH_STATS_EN adds saturating request and
// taken counters; without it both counter ports read as zero.
module branch_ctrl (
    input  logic          clk,
    input  logic          rstn,
    branch_ctrl_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EVAL = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    typedef struct packed {
        logic zero;
        logic great;
        logic less;
        logic lez;
        logic ltz;
    } flags_t;

    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_BEQ  = 4'd1;
    localparam logic [3:0] OP_BNE  = 4'd2;
    localparam logic [3:0] OP_BLEZ = 4'd3;
    localparam logic [3:0] OP_BGTZ = 4'd4;
    localparam logic [3:0] OP_BLTZ = 4'd5;
    localparam logic [3:0] OP_BGEZ = 4'd6;
    localparam logic [3:0] OP_J    = 4'd7;
    localparam logic [3:0] OP_JAL  = 4'd8;
    localparam logic [3:0] OP_JR   = 4'd9;
    localparam logic [3:0] OP_JALR = 4'd10;
    localparam logic [3:0] OP_BGT  = 4'd11;
    localparam logic [3:0] OP_BLT  = 4'd12;

    state_t      state_q, state_d;

    // operands captured on the accepting edge
    logic [3:0]  br_op_q, br_op_d;
    flags_t      flags_q, flags_d;
    logic [31:0] pc4_q, pc4_d;
    logic [15:0] imm16_q, imm16_d;
    logic [25:0] instr_index_q, instr_index_d;
    logic [31:0] rs_val_q, rs_val_d;

    // registered result
    logic        taken_q, taken_d;
    logic [31:0] npc_q, npc_d;
    logic        link_we_q, link_we_d;
    logic [31:0] link_val_q, link_val_d;
    logic        bad_op_q, bad_op_d;

    // combinational resolution of the captured request
    logic        eval_taken;
    logic [31:0] eval_npc;
    logic        eval_link;
    logic        eval_bad;
    logic [31:0] eval_target;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    // Request sequencing and operand capture; operands only move on accept
    always_comb begin
        state_d       = state_q;
        br_op_d       = br_op_q;
        flags_d       = flags_q;
        pc4_d         = pc4_q;
        imm16_d       = imm16_q;
        instr_index_d = instr_index_q;
        rs_val_d      = rs_val_q;

        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    state_d       = ST_EVAL;
                    br_op_d       = bus.br_op;
                    flags_d       = '{zero:  bus.zero,
                                      great: bus.great,
                                      less:  bus.less,
                                      lez:   bus.lez,
                                      ltz:   bus.ltz};
                    pc4_d         = bus.pc4;
                    imm16_d       = bus.imm16;
                    instr_index_d = bus.instr_index;
                    rs_val_d      = bus.rs_val;
                end
            end
            ST_EVAL: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                if (bus.res_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Condition, target and link decode for the captured operation
    always_comb begin
        eval_taken    = 1'b0;
        eval_link     = 1'b0;
        eval_bad      = 1'b0;
        branch_target = pc4_q + {{14{imm16_q[15]}}, imm16_q, 2'b00};
        jump_target   = {pc4_q[31:28], instr_index_q, 2'b00};
        eval_target   = branch_target;

        case (br_op_q)
            OP_NOP: begin
                eval_taken = 1'b0;
            end
            OP_BEQ: begin
                eval_taken = flags_q.zero;
            end
            OP_BNE: begin
                eval_taken = !flags_q.zero;
            end
            OP_BLEZ: begin
                eval_taken = flags_q.lez;
            end
            OP_BGTZ: begin
                eval_taken = !flags_q.lez;
            end
            OP_BLTZ: begin
                eval_taken = flags_q.ltz;
            end
            OP_BGEZ: begin
                eval_taken = !flags_q.ltz;
            end
            OP_J: begin
                eval_taken  = 1'b1;
                eval_target = jump_target;
            end
            OP_JAL: begin
                eval_taken  = 1'b1;
                eval_link   = 1'b1;
                eval_target = jump_target;
            end
            OP_JR: begin
                eval_taken  = 1'b1;
                eval_target = rs_val_q;
            end
            OP_JALR: begin
                eval_taken  = 1'b1;
                eval_link   = 1'b1;
                eval_target = rs_val_q;
            end
            OP_BGT: begin
                eval_taken = flags_q.great;
            end
            OP_BLT: begin
                eval_taken = flags_q.less;
            end
            default: begin
                eval_bad = 1'b1;
            end
        endcase

        eval_npc = eval_taken ? eval_target : pc4_q;
    end

    // Result registers load only in EVAL and otherwise keep their last value
    always_comb begin
        taken_d    = taken_q;
        npc_d      = npc_q;
        link_we_d  = link_we_q;
        link_val_d = link_val_q;
        bad_op_d   = bad_op_q;

        if (state_q == ST_EVAL) begin
            taken_d    = eval_taken;
            npc_d      = eval_npc;
            link_we_d  = eval_link;
            link_val_d = eval_link ? pc4_q : 32'h0;
            bad_op_d   = eval_bad;
        end
    end

    // State, operand and result registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q       <= ST_IDLE;
            br_op_q       <= 4'h0;
            flags_q       <= '0;
            pc4_q         <= 32'h0;
            imm16_q       <= 16'h0;
            instr_index_q <= 26'h0;
            rs_val_q      <= 32'h0;
            taken_q       <= 1'b0;
            npc_q         <= 32'h0;
            link_we_q     <= 1'b0;
            link_val_q    <= 32'h0;
            bad_op_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            br_op_q       <= br_op_d;
            flags_q       <= flags_d;
            pc4_q         <= pc4_d;
            imm16_q       <= imm16_d;
            instr_index_q <= instr_index_d;
            rs_val_q      <= rs_val_d;
            taken_q       <= taken_d;
            npc_q         <= npc_d;
            link_we_q     <= link_we_d;
            link_val_q    <= link_val_d;
            bad_op_q      <= bad_op_d;
        end
    end

`ifdef BRANCH_STATS_EN
    logic [31:0] br_count_q, br_count_d;
    logic [31:0] br_taken_count_q, br_taken_count_d;

    // Saturating counters bumped once per resolved request on EVAL->HOLD
    always_comb begin
        br_count_d       = br_count_q;
        br_taken_count_d = br_taken_count_q;
        if (state_q == ST_EVAL) begin
            if (br_count_q != 32'hFFFF_FFFF) begin
                br_count_d = br_count_q + 32'd1;
            end
            if (eval_taken && (br_taken_count_q != 32'hFFFF_FFFF)) begin
                br_taken_count_d = br_taken_count_q + 32'd1;
            end
        end
    end

    // Counter registers cleared by reset
    always_ff @(posedge clk) begin
        if (!rstn) begin
            br_count_q       <= 32'h0;
            br_taken_count_q <= 32'h0;
        end else begin
            br_count_q       <= br_count_d;
            br_taken_count_q <= br_taken_count_d;
        end
    end

    assign bus.br_count       = br_count_q;
    assign bus.br_taken_count = br_taken_count_q;
`else
    assign bus.br_count       = 32'h0;
    assign bus.br_taken_count = 32'h0;
`endif

    assign bus.ready     = (state_q == ST_IDLE);
    assign bus.res_valid = (state_q == ST_HOLD);
    assign bus.taken     = taken_q;
    assign bus.npc       = npc_q;
    assign bus.link_we   = link_we_q;
    assign bus.link_val  = link_val_q;
    assign bus.bad_op    = bad_op_q;

endmodule

// File: tb/tb_branch_ctrl.sv
// tb_branch_ctrl: directed bench for branch_ctrl with a transaction-level
// reference model checked every cycle plus hand-computed literal checks.
module tb_branch_ctrl;

    logic clk  = 1'b0;
    logic rstn = 1'b0;

    branch_ctrl_if bus ();

    branch_ctrl dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    typedef struct packed {
        logic        taken;
        logic [31:0] npc;
        logic        link_we;
        logic [31:0] link_val;
        logic        bad_op;
    } res_t;

    // Compare one value and report a mismatch
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Reference resolution of one request from the operation table
    function automatic res_t predict(input logic [3:0] op, input logic [4:0] fl,
                                     input logic [31:0] pc4, input logic [15:0] imm,
                                     input logic [25:0] idx, input logic [31:0] rs);
        res_t        r;
        int          off;
        logic [31:0] br_dest;
        logic [31:0] j_dest;
        logic        zero, great, less, lez, ltz;
        {zero, great, less, lez, ltz} = fl;
        off     = $signed(imm);
        off     = off * 4;
        br_dest = pc4 + off;
        j_dest  = (pc4 & 32'hF000_0000) | ({6'b0, idx} * 32'd4);
        r       = '0;
        r.npc   = pc4;
        case (op)
            4'd1:  if (zero)   begin r.taken = 1; r.npc = br_dest; end
            4'd2:  if (!zero)  begin r.taken = 1; r.npc = br_dest; end
            4'd3:  if (lez)    begin r.taken = 1; r.npc = br_dest; end
            4'd4:  if (!lez)   begin r.taken = 1; r.npc = br_dest; end
            4'd5:  if (ltz)    begin r.taken = 1; r.npc = br_dest; end
            4'd6:  if (!ltz)   begin r.taken = 1; r.npc = br_dest; end
            4'd7:  begin r.taken = 1; r.npc = j_dest; end
            4'd8:  begin r.taken = 1; r.npc = j_dest; r.link_we = 1; r.link_val = pc4; end
            4'd9:  begin r.taken = 1; r.npc = rs; end
            4'd10: begin r.taken = 1; r.npc = rs; r.link_we = 1; r.link_val = pc4; end
            4'd11: if (great)  begin r.taken = 1; r.npc = br_dest; end
            4'd12: if (less)   begin r.taken = 1; r.npc = br_dest; end
            4'd13, 4'd14, 4'd15: r.bad_op = 1;
            default: ;
        endcase
        return r;
    endfunction

    // Transaction model: tracks accept cycle, pending result and counters
    int          m_cycle  = 0;
    int          m_accept = 0;
    bit          m_active = 0;
    bit          m_armed  = 0;
    res_t        m_pend   = '0;
    res_t        m_out    = '0;
    logic [31:0] m_cnt    = 0;
    logic [31:0] m_tcnt   = 0;

    always @(posedge clk) begin
        m_cycle = m_cycle + 1;
        if (!rstn) begin
            m_active = 0;
            m_out    = '0;
            m_cnt    = 0;
            m_tcnt   = 0;
            m_armed  = 1;
        end else if (m_active) begin
            if (m_cycle == m_accept + 1) begin
                m_out = m_pend;
                if (m_cnt != 32'hFFFF_FFFF) m_cnt = m_cnt + 1;
                if (m_pend.taken && m_tcnt != 32'hFFFF_FFFF) m_tcnt = m_tcnt + 1;
            end else if (bus.res_ack) begin
                m_active = 0;
            end
        end else if (bus.start) begin
            m_active = 1;
            m_accept = m_cycle;
            m_pend   = predict(bus.br_op, {bus.zero, bus.great, bus.less, bus.lez, bus.ltz},
                               bus.pc4, bus.imm16, bus.instr_index, bus.rs_val);
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        if (m_armed) begin
            checkOutput("ready",     bus.ready,     !m_active);
            checkOutput("res_valid", bus.res_valid, m_active && (m_cycle >= m_accept + 1));
            checkOutput("taken",     bus.taken,     m_out.taken);
            checkOutput("npc",       bus.npc,       m_out.npc);
            checkOutput("link_we",   bus.link_we,   m_out.link_we);
            checkOutput("link_val",  bus.link_val,  m_out.link_val);
            checkOutput("bad_op",    bus.bad_op,    m_out.bad_op);
`ifdef BRANCH_STATS_EN
            checkOutput("br_count",       bus.br_count,       m_cnt);
            checkOutput("br_taken_count", bus.br_taken_count, m_tcnt);
`else
            checkOutput("br_count",       bus.br_count,       32'h0);
            checkOutput("br_taken_count", bus.br_taken_count, 32'h0);
`endif
        end
    end

    // Present one request at a negedge with the unit idle; returns in HOLD
    task automatic applyStimulus(input logic [3:0] op, input logic [4:0] fl,
                                 input logic [31:0] pc4, input logic [15:0] imm,
                                 input logic [25:0] idx, input logic [31:0] rs);
        bus.start       = 1'b1;
        bus.br_op       = op;
        {bus.zero, bus.great, bus.less, bus.lez, bus.ltz} = fl;
        bus.pc4         = pc4;
        bus.imm16       = imm;
        bus.instr_index = idx;
        bus.rs_val      = rs;
        @(negedge clk);
        bus.start       = 1'b0;
        bus.br_op       = ~op;
        {bus.zero, bus.great, bus.less, bus.lez, bus.ltz} = ~fl;
        bus.pc4         = ~pc4;
        bus.imm16       = ~imm;
        bus.instr_index = ~idx;
        bus.rs_val      = ~rs;
        checkOutput("eval_res_valid", bus.res_valid, 1'b0);
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.res_valid && n < 8) begin
                @(negedge clk);
                n++;
            end
            checkOutput("res_valid_latency", bus.res_valid, 1'b1);
            checkOutput("latency_extra_cycles", n, 0);
        end
    endtask

    // Stall for a number of cycles, then acknowledge for one cycle
    task automatic ackResult(input int stall);
        repeat (stall) @(negedge clk);
        bus.res_ack = 1'b1;
        @(negedge clk);
        bus.res_ack = 1'b0;
    endtask

    task automatic doReset();
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
    endtask

    initial begin
        bus.start       = 1'b0;
        bus.res_ack     = 1'b0;
        bus.br_op       = 4'h0;
        {bus.zero, bus.great, bus.less, bus.lez, bus.ltz} = 5'b0;
        bus.pc4         = 32'h0;
        bus.imm16       = 16'h0;
        bus.instr_index = 26'h0;
        bus.rs_val      = 32'h0;

        doReset();
        checkOutput("reset_ready",     bus.ready,     1'b1);
        checkOutput("reset_res_valid", bus.res_valid, 1'b0);
        checkOutput("reset_npc",       bus.npc,       32'h0);

        // BEQ taken with negative offset, stalled for 5 cycles
        applyStimulus(4'd1, 5'b10000, 32'h0040_0010, 16'hFFFC, 26'h0, 32'h0);
        checkOutput("beq_taken",   bus.taken,   1'b1);
        checkOutput("beq_npc",     bus.npc,     32'h0040_0000);
        checkOutput("beq_link_we", bus.link_we, 1'b0);
        repeat (5) @(negedge clk);
        checkOutput("beq_stall_valid", bus.res_valid, 1'b1);
        checkOutput("beq_stall_npc",   bus.npc,       32'h0040_0000);
        ackResult(0);
        checkOutput("beq_ack_ready", bus.ready, 1'b1);

        // BGEZ not taken
        applyStimulus(4'd6, 5'b00001, 32'h0000_1000, 16'h0040, 26'h0, 32'h0);
        checkOutput("bgez_taken", bus.taken, 1'b0);
        checkOutput("bgez_npc",   bus.npc,   32'h0000_1000);
        ackResult(1);

        // JAL region jump with link
        applyStimulus(4'd8, 5'b00000, 32'hA000_0004, 16'h0000, 26'h000_0100, 32'h0);
        checkOutput("jal_npc",      bus.npc,      32'hA000_0400);
        checkOutput("jal_link_we",  bus.link_we,  1'b1);
        checkOutput("jal_link_val", bus.link_val, 32'hA000_0004);
        ackResult(0);

        // JALR keeps low bits of the register target
        applyStimulus(4'd10, 5'b00000, 32'h0000_2000, 16'h0000, 26'h0, 32'h0000_3003);
        checkOutput("jalr_npc",     bus.npc,     32'h0000_3003);
        checkOutput("jalr_link_we", bus.link_we, 1'b1);
        ackResult(0);

        // Illegal opcode
        applyStimulus(4'd14, 5'b11111, 32'h0000_5000, 16'h0010, 26'h0, 32'h0);
        checkOutput("illegal_bad_op", bus.bad_op, 1'b1);
        checkOutput("illegal_taken",  bus.taken,  1'b0);
        checkOutput("illegal_npc",    bus.npc,    32'h0000_5000);
        ackResult(0);

        // BLT with silent wrap-around of the target
        applyStimulus(4'd12, 5'b00100, 32'hFFFF_FFF0, 16'h0010, 26'h0, 32'h0);
        checkOutput("wrap_npc", bus.npc, 32'h0000_0030);
        ackResult(0);

        // start during HOLD must be ignored
        applyStimulus(4'd2, 5'b00000, 32'h0000_0100, 16'h0002, 26'h0, 32'h0);
        bus.start = 1'b1;
        bus.br_op = 4'd8;
        repeat (3) @(negedge clk);
        bus.start = 1'b0;
        ackResult(0);
        repeat (3) @(negedge clk);
        checkOutput("no_second_result", bus.res_valid, 1'b0);
        checkOutput("no_second_link",   bus.link_we,   1'b0);

        // Sweep every opcode with assorted flags and operands
        for (int i = 0; i < 16; i++) begin
            applyStimulus(4'(i), 5'($urandom), $urandom, 16'($urandom),
                          26'($urandom), $urandom);
            ackResult(i % 3);
        end

        // Reset while a result is held
        applyStimulus(4'd1, 5'b10000, 32'h0000_0800, 16'h0004, 26'h0, 32'h0);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("rst_hold_res_valid", bus.res_valid, 1'b0);
        checkOutput("rst_hold_ready",     bus.ready,     1'b1);
        checkOutput("rst_hold_npc",       bus.npc,       32'h0);
        checkOutput("rst_hold_taken",     bus.taken,     1'b0);
        rstn = 1'b1;
        @(negedge clk);

        // Three back-to-back requests, two taken
        applyStimulus(4'd1, 5'b10000, 32'h0000_0100, 16'h0001, 26'h0, 32'h0);
        ackResult(0);
        applyStimulus(4'd2, 5'b10000, 32'h0000_0200, 16'h0001, 26'h0, 32'h0);
        ackResult(0);
        applyStimulus(4'd7, 5'b00000, 32'h0000_0300, 16'h0000, 26'h0000_040, 32'h0);
        ackResult(0);
`ifdef BRANCH_STATS_EN
        checkOutput("stats_br_count",       bus.br_count,       32'd3);
        checkOutput("stats_br_taken_count", bus.br_taken_count, 32'd2);
`else
        checkOutput("stats_br_count",       bus.br_count,       32'd0);
        checkOutput("stats_br_taken_count", bus.br_taken_count, 32'd0);
`endif

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    // Global time bound
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
